seq_multiplier: RTL

Iterative radix-2 shift-add multiplier: parametrised successor to the combinational unsigned array multiplier. Trades area for latency by retiring one partial-product row per clock. Adds two things the array multiplier lacks: per-operation signed (two's complement) or unsigned mode, and a valid/ready handshake on both sides so it can sit directly on a datapath bus with backpressure.

---
 rtl/seq_multiplier.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier with per-operation signed/unsigned
// mode and valid/ready handshakes on both the operand and the product side.
// One partial-product row is retired per clock; a W-bit product takes W
// RUN cycles after acceptance, then waits in DONE until the consumer takes it.
module seq_multiplier #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   p,
    output logic             busy
);

    // Counter only has to reach W-1; keep at least one bit for tiny W.
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    // Captured operands: the caller may change x/is_signed while we iterate.
    logic [W-1:0]      x_reg;
    logic              sgn_reg;

    // Accumulator: high half is W+1 bits so the partial sum never overflows;
    // low half starts as y and is consumed one bit per step from the LSB end.
    logic [W:0]        hi_reg;
    logic [W-1:0]      lo_reg;
    logic [CW-1:0]     cnt_reg;
    logic [2*W-1:0]    p_reg;

    // One-step datapath results.
    logic              last_step;
    logic              do_sub;
    logic [W+1:0]      hi_ext;
    logic [W+1:0]      x_ext;
    logic [W+1:0]      sum;
    logic              shift_in;
    logic [W:0]        hi_step;
    logic [W-1:0]      lo_step;
    logic [2*W-1:0]    prod_step;

    // Handshake events.
    logic              accept;
    logic              retire;

    assign accept    = (state_reg == IDLE) && in_valid;
    assign retire    = (state_reg == DONE) && out_ready;
    assign last_step = (cnt_reg == CW'(W - 1));

    // Outputs depend only on state and registers, never on inputs directly.
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign p         = p_reg;

    // One shift-add step. Work in W+2 bits so both the unsigned carry-out and
    // the signed W+1-bit sign bit are available. In signed mode the final row
    // is subtracted because the MSB of y carries weight -2^(W-1).
    always_comb begin
        hi_ext   = sgn_reg ? {hi_reg[W], hi_reg} : {1'b0, hi_reg};
        x_ext    = sgn_reg ? {{2{x_reg[W-1]}}, x_reg} : {2'b00, x_reg};
        do_sub   = sgn_reg && last_step;
        sum      = hi_ext;
        if (lo_reg[0]) begin
            if (do_sub) begin
                sum = hi_ext - x_ext;
            end else begin
                sum = hi_ext + x_ext;
            end
        end
        shift_in  = sgn_reg ? sum[W] : sum[W+1];
        hi_step   = {shift_in, sum[W:1]};
        lo_step   = {sum[0], lo_reg[W-1:1]};
        prod_step = {hi_step[W-1:0], lo_step};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, iterate W steps, hold in DONE until taken.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (retire) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture and accumulator iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg   <= '0;
            sgn_reg <= 1'b0;
            hi_reg  <= '0;
            lo_reg  <= '0;
            cnt_reg <= '0;
        end else if (accept) begin
            x_reg   <= x;
            sgn_reg <= is_signed;
            hi_reg  <= '0;
            lo_reg  <= y;
            cnt_reg <= '0;
        end else if (state_reg == RUN) begin
            hi_reg  <= hi_step;
            lo_reg  <= lo_step;
            cnt_reg <= last_step ? '0 : cnt_reg + 1'b1;
        end
    end

    // Product register: loads on the final step and holds until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg <= '0;
        end else if ((state_reg == RUN) && last_step) begin
            p_reg <= prod_step;
        end
    end

endmodule
